// File: rtl/game_timer.sv
// Round countdown timer: captures setpoint from switches, loads on pulse, counts seconds while running.
// Latency: load visible 1 cycle after pulse; BCD digits combinational from count; optional warnFlag 1 cycle behind count.
// Backpressure: none; level/pulse controls from the game FSM, sticky timeOutFlag needs no handshake. Optional: GAME_TIMER_WARN_EN.
module game_timer #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DEFAULT_SEC = 30,
    parameter int WARN_SEC    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enableSetTimeFlag,
    input  logic [6:0] timeSW,
    input  logic       setTimeMaxFlag,
    input  logic       startGameFlag,
    input  logic       clearFlag,
    output logic       timeOutFlag,
    output logic [6:0] timeLeft,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       tick_s,
    output logic       warnFlag
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    MAX_SEC    = 7'd99;
    localparam logic [6:0]    SET_RST    = 7'(DEFAULT_SEC);

    logic [6:0]    setpoint_q, setpoint_d;
    logic [6:0]    count_q,    count_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic          timeout_q,  timeout_d;
    logic          tick_q,     tick_d;

    // Setpoint follows the clamped switches while setup is enabled, otherwise holds.
    always_comb begin
        setpoint_d = setpoint_q;
        if (enableSetTimeFlag) begin
            setpoint_d = (timeSW > MAX_SEC) ? MAX_SEC : timeSW;
        end
    end

    // Countdown next state: clear beats load, load beats the running count.
    always_comb begin
        count_d   = count_q;
        presc_d   = presc_q;
        timeout_d = timeout_q;
        tick_d    = 1'b0;
        if (clearFlag) begin
            count_d   = 7'd0;
            presc_d   = '0;
            timeout_d = 1'b0;
        end else if (setTimeMaxFlag) begin
            // Reload restarts the current second as well as the count.
            count_d   = setpoint_q;
            presc_d   = '0;
            timeout_d = 1'b0;
        end else if (startGameFlag && !timeout_q) begin
            if (count_q == 7'd0) begin
                // A round loaded with zero expires on the first running edge.
                timeout_d = 1'b1;
            end else if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                count_d = count_q - 7'd1;
                tick_d  = 1'b1;
                if (count_q == 7'd1) begin
                    timeout_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        // startGameFlag low or timed out: count and partial second both hold.
    end

    // Timer state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setpoint_q <= SET_RST;
            count_q    <= 7'd0;
            presc_q    <= '0;
            timeout_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            setpoint_q <= setpoint_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            timeout_q  <= timeout_d;
            tick_q     <= tick_d;
        end
    end

    assign timeOutFlag = timeout_q;
    assign timeLeft    = count_q;
    assign tick_s      = tick_q;

    // Display digits; count never exceeds 99 so both are valid BCD.
    always_comb begin
        secTens = 4'(count_q / 7'd10);
        secOnes = 4'(count_q % 7'd10);
    end

`ifdef GAME_TIMER_WARN_EN
    localparam logic [6:0] WARN_LIM = 7'(WARN_SEC);

    logic warn_q, warn_d;

    // Low-time warning: only while actively running and not yet expired.
    always_comb begin
        warn_d = (count_q >= 7'd1) && (count_q <= WARN_LIM) && startGameFlag && !timeout_q;
    end

    // Registered so the warning lamp is glitch-free; trails count by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warnFlag = warn_q;
`else
    assign warnFlag = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer with a running-cycle countdown model.
// Latency: model advanced once per clock, outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; all stimulus is level/pulse driven from initial blocks.
module tb_game_timer;

    localparam int TD   = 4;
    localparam int DEF  = 30;
    localparam int WARN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enableSetTimeFlag;
    logic [6:0] timeSW;
    logic       setTimeMaxFlag;
    logic       startGameFlag;
    logic       clearFlag;
    logic       timeOutFlag;
    logic [6:0] timeLeft;
    logic [3:0] secTens;
    logic [3:0] secOnes;
    logic       tick_s;
    logic       warnFlag;

    int checks   = 0;
    int failures = 0;

    // Model: round loaded with m_len seconds, m_run running cycles elapsed since load.
    int m_set;
    int m_len;
    int m_run;
    bit m_tick;
    bit m_warn;

    game_timer #(.TICK_DIV(TD), .DEFAULT_SEC(DEF), .WARN_SEC(WARN)) dut (
        .clk               (clk),
        .rst               (rst),
        .enableSetTimeFlag (enableSetTimeFlag),
        .timeSW            (timeSW),
        .setTimeMaxFlag    (setTimeMaxFlag),
        .startGameFlag     (startGameFlag),
        .clearFlag         (clearFlag),
        .timeOutFlag       (timeOutFlag),
        .timeLeft          (timeLeft),
        .secTens           (secTens),
        .secOnes           (secOnes),
        .tick_s            (tick_s),
        .warnFlag          (warnFlag)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int done;
        done = m_run / TD;
        if (done > m_len) done = m_len;
        return m_len - done;
    endfunction

    function automatic bit m_to();
        if (m_len == 0) return (m_run >= 1);
        return (m_run >= m_len * TD);
    endfunction

    function automatic bit exp_warn();
`ifdef GAME_TIMER_WARN_EN
        return m_warn;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [17:0] exp_vec();
        int c;
        c = m_count();
        return {m_to(), 7'(c), 4'(c / 10), 4'(c % 10), m_tick, exp_warn()};
    endfunction

    task automatic model_reset();
        m_set  = DEF;
        m_len  = 0;
        m_run  = 0;
        m_tick = 1'b0;
        m_warn = 1'b0;
    endtask

    // Advance model with the currently driven inputs, then clock the DUT and settle.
    task automatic step();
        int c0;
        bit to0;
        c0  = m_count();
        to0 = m_to();
        m_warn = (c0 >= 1) && (c0 <= WARN) && startGameFlag && !to0;
        m_tick = 1'b0;
        if (clearFlag) begin
            m_len = 0;
            m_run = 0;
        end else if (setTimeMaxFlag) begin
            m_len = m_set;
            m_run = 0;
        end else if (startGameFlag && !to0) begin
            m_run++;
            m_tick = (m_count() != c0);
        end
        if (enableSetTimeFlag) m_set = (timeSW > 99) ? 99 : int'(timeSW);
        @(posedge clk);
        #1;
    endtask

    task automatic load_sw(input int sw);
        enableSetTimeFlag = 1'b1;
        timeSW = 7'(sw);
        step();
        enableSetTimeFlag = 1'b0;
        setTimeMaxFlag = 1'b1;
        step();
        setTimeMaxFlag = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enableSetTimeFlag = 1'b0;
        timeSW = 7'd0;
        setTimeMaxFlag = 1'b0;
        startGameFlag = 1'b0;
        clearFlag = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({timeOutFlag, timeLeft, secTens, secOnes, tick_s, warnFlag} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {timeOutFlag, timeLeft, secTens, secOnes, tick_s, warnFlag});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        setTimeMaxFlag = 1'b1;
        step();
        setTimeMaxFlag = 1'b0;
        checks++;
        if (timeLeft !== 7'd30) begin
            failures++;
            $display("FAIL default_load_timeLeft: got %0d expected 30", timeLeft);
        end
        checks++;
        if ({secTens, secOnes} !== 8'h30) begin
            failures++;
            $display("FAIL default_load_bcd: got %h expected 30", {secTens, secOnes});
        end
        checks++;
        if (timeOutFlag !== 1'b0) begin
            failures++;
            $display("FAIL default_load_timeout: got %0b expected 0", timeOutFlag);
        end
    endtask

    task automatic test_countdown();
        load_sw(3);
        checks++;
        if (timeLeft !== 7'd3) begin
            failures++;
            $display("FAIL countdown_load: got %0d expected 3", timeLeft);
        end
        startGameFlag = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if (tick_s !== ((i % 4 == 0) && i <= 12)) begin
                failures++;
                $display("FAIL countdown_tick cyc %0d: got %0b expected %0b", i, tick_s, (i % 4 == 0) && i <= 12);
            end
            checks++;
            if (timeLeft !== 7'((i >= 12) ? 0 : 3 - i / 4)) begin
                failures++;
                $display("FAIL countdown_left cyc %0d: got %0d expected %0d", i, timeLeft, (i >= 12) ? 0 : 3 - i / 4);
            end
            checks++;
            if (timeOutFlag !== (i >= 12)) begin
                failures++;
                $display("FAIL countdown_timeout cyc %0d: got %0b expected %0b", i, timeOutFlag, i >= 12);
            end
            checks++;
            if (warnFlag !== exp_warn()) begin
                failures++;
                $display("FAIL countdown_warn cyc %0d: got %0b expected %0b", i, warnFlag, exp_warn());
            end
        end
        startGameFlag = 1'b0;
        step();
        checks++;
        if (timeOutFlag !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %0b expected 1", timeOutFlag);
        end
    endtask

    task automatic test_clamp();
        load_sw(120);
        checks++;
        if (timeLeft !== 7'd99 || secTens !== 4'd9 || secOnes !== 4'd9) begin
            failures++;
            $display("FAIL clamp_99: got %0d (%0d,%0d) expected 99 (9,9)", timeLeft, secTens, secOnes);
        end
    endtask

    task automatic test_pause();
        load_sw(5);
        startGameFlag = 1'b1;
        repeat (6) step();
        checks++;
        if (timeLeft !== 7'd4) begin
            failures++;
            $display("FAIL pause_before: got %0d expected 4", timeLeft);
        end
        startGameFlag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (timeLeft !== 7'd4 || tick_s !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold cyc %0d: got left=%0d tick=%0b expected left=4 tick=0", i, timeLeft, tick_s);
            end
        end
        startGameFlag = 1'b1;
        step();
        checks++;
        if (tick_s !== 1'b0 || timeLeft !== 7'd4) begin
            failures++;
            $display("FAIL resume_first: got left=%0d tick=%0b expected left=4 tick=0", timeLeft, tick_s);
        end
        step();
        checks++;
        if (tick_s !== 1'b1 || timeLeft !== 7'd3) begin
            failures++;
            $display("FAIL resume_second: got left=%0d tick=%0b expected left=3 tick=1", timeLeft, tick_s);
        end
        startGameFlag = 1'b0;
    endtask

    task automatic test_clear_priority();
        load_sw(1);
        startGameFlag = 1'b1;
        repeat (5) step();
        checks++;
        if (timeOutFlag !== 1'b1) begin
            failures++;
            $display("FAIL clear_pre_timeout: got %0b expected 1", timeOutFlag);
        end
        startGameFlag = 1'b0;
        clearFlag = 1'b1;
        setTimeMaxFlag = 1'b1;
        step();
        clearFlag = 1'b0;
        setTimeMaxFlag = 1'b0;
        checks++;
        if (timeLeft !== 7'd0 || timeOutFlag !== 1'b0) begin
            failures++;
            $display("FAIL clear_wins: got left=%0d to=%0b expected left=0 to=0", timeLeft, timeOutFlag);
        end
        setTimeMaxFlag = 1'b1;
        step();
        setTimeMaxFlag = 1'b0;
        checks++;
        if (timeLeft !== 7'd1) begin
            failures++;
            $display("FAIL reload_after_clear: got %0d expected 1", timeLeft);
        end
    endtask

    task automatic test_load_zero();
        load_sw(0);
        startGameFlag = 1'b1;
        checks++;
        if (timeOutFlag !== 1'b0) begin
            failures++;
            $display("FAIL zero_before_run: got %0b expected 0", timeOutFlag);
        end
        step();
        checks++;
        if (timeOutFlag !== 1'b1 || tick_s !== 1'b0) begin
            failures++;
            $display("FAIL zero_timeout: got to=%0b tick=%0b expected to=1 tick=0", timeOutFlag, tick_s);
        end
        startGameFlag = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enableSetTimeFlag = ($urandom_range(0, 3) == 0);
            timeSW = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
            setTimeMaxFlag = ($urandom_range(0, 29) == 0);
            clearFlag = ($urandom_range(0, 89) == 0);
            startGameFlag = ($urandom_range(0, 7) != 0);
            step();
            checks++;
            if ({timeOutFlag, timeLeft, secTens, secOnes, tick_s, warnFlag} !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc %0d: got %h expected %h", i,
                         {timeOutFlag, timeLeft, secTens, secOnes, tick_s, warnFlag}, exp_vec());
            end
        end
        enableSetTimeFlag = 1'b0;
        setTimeMaxFlag = 1'b0;
        clearFlag = 1'b0;
        startGameFlag = 1'b0;
    endtask

    task automatic test_async_reset();
        load_sw(3);
        startGameFlag = 1'b1;
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({timeOutFlag, timeLeft, secTens, secOnes, tick_s, warnFlag} !== 18'd0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 0",
                     {timeOutFlag, timeLeft, secTens, secOnes, tick_s, warnFlag});
        end
        startGameFlag = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        setTimeMaxFlag = 1'b1;
        step();
        setTimeMaxFlag = 1'b0;
        checks++;
        if (timeLeft !== 7'd30) begin
            failures++;
            $display("FAIL setpoint_after_reset: got %0d expected 30", timeLeft);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_clamp();
        test_pause();
        test_clear_priority();
        test_load_zero();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
